// File: rtl/emern_video_pkg.sv
// emern_video_pkg: 640x480@60 timing defaults, pixel packing and the colour-bar function.
package emern_video_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam bit SYNC_ACTIVE_LOW = 1'b0;
  localparam int MAX_BPC = 4;
  typedef struct packed {
    logic [MAX_BPC-1:0] r;
    logic [MAX_BPC-1:0] g;
    logic [MAX_BPC-1:0] b;
  } pixel_t;
  // bar index k = c*8/h_active; its bits are the {r,g,b} on/off flags
  function automatic logic [2:0] bar_color(input int unsigned c, input int unsigned h_active);
    return 3'(c * 8 / h_active);
  endfunction
endpackage

// File: rtl/emern_delay_line.sv
// emern_delay_line: DEPTH-stage shift register with async reset; DEPTH=0 is a wire.
module emern_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  if (DEPTH == 0) begin : g_wire
    assign q = d;
  end else begin : g_sr
    logic [DEPTH-1:0][WIDTH-1:0] sr;
    logic [DEPTH:0][WIDTH-1:0] chain;
    assign chain = {sr, d};
    assign q = chain[DEPTH];
    always_ff @(posedge clk or posedge rst)
      if (rst) sr <= {DEPTH{RESET_VAL}};
      else sr <= chain[DEPTH-1:0];
  end
endmodule

// File: rtl/emern_video_out.sv
// emern_video_out: raster counters, latency-aligned sync/blank/colour pad stage, vblank command window.
// Define EMERN_COLOR_BAR_EN to add test_en and an 8-bar test pattern.
module emern_video_out
  import emern_video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter bit SYNC_POL = SYNC_ACTIVE_LOW,
  parameter int BPC = 2,
  parameter int PIPE_DEPTH = 2,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int CW_H = $clog2(H_TOTAL),
  localparam int CW_V = $clog2(V_TOTAL)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef EMERN_COLOR_BAR_EN
  input  logic             test_en,
`endif
  input  logic [3*BPC-1:0] pixel_in,
  output logic [CW_V-1:0]  row,
  output logic [CW_H-1:0]  col,
  output logic             frame_start,
  output logic             h_sync,
  output logic             v_sync,
  output logic [3*BPC-1:0] rgb_out,
  output logic             cmd_en,
  output logic             blank
);
  localparam logic [CW_H-1:0] H_LAST = CW_H'(H_TOTAL - 1);
  localparam logic [CW_H-1:0] H_ACT = CW_H'(H_ACTIVE);
  localparam logic [CW_H-1:0] HS_BEG = CW_H'(H_ACTIVE + H_FP);
  localparam logic [CW_H-1:0] HS_END = CW_H'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW_V-1:0] V_LAST = CW_V'(V_TOTAL - 1);
  localparam logic [CW_V-1:0] V_ACT = CW_V'(V_ACTIVE);
  localparam logic [CW_V-1:0] VS_BEG = CW_V'(V_ACTIVE + V_FP);
  localparam logic [CW_V-1:0] VS_END = CW_V'(V_ACTIVE + V_FP + V_SYNC);
  if (BPC < 1 || BPC > 4 || PIPE_DEPTH < 0 || PIPE_DEPTH > 8 ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
    $error("emern_video_out: illegal parameter set");
  end
  logic h_wrap, v_wrap, act, hs, vs, act_d, hs_d, vs_d;
  logic [3*BPC-1:0] pix;
  assign h_wrap = col == H_LAST;
  assign v_wrap = row == V_LAST;
  assign act = col < H_ACT && row < V_ACT;
  assign hs = col >= HS_BEG && col < HS_END;
  assign vs = row >= VS_BEG && row < VS_END;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
      frame_start <= 1'b0;
      cmd_en <= 1'b0;
    end else begin
      col <= h_wrap ? '0 : col + CW_H'(1);
      if (h_wrap) row <= v_wrap ? '0 : row + CW_V'(1);
      frame_start <= h_wrap && v_wrap;
      cmd_en <= row >= V_ACT;
    end
  // reset value {act,hs,vs}=0 means blank with syncs deasserted, so stale data never escapes
  emern_delay_line #(.WIDTH(3), .DEPTH(PIPE_DEPTH), .RESET_VAL(3'b000)) u_sync_dly (
    .clk(clk),
    .rst(rst),
    .d({act, hs, vs}),
    .q({act_d, hs_d, vs_d})
  );
`ifdef EMERN_COLOR_BAR_EN
  logic [CW_H-1:0] col_d;
  logic test_d;
  logic [2:0] bar;
  emern_delay_line #(.WIDTH(CW_H + 1), .DEPTH(PIPE_DEPTH), .RESET_VAL('0)) u_bar_dly (
    .clk(clk),
    .rst(rst),
    .d({test_en, col}),
    .q({test_d, col_d})
  );
  assign bar = bar_color(32'(col_d), H_ACTIVE);
  assign pix = test_d ? {{BPC{bar[2]}}, {BPC{bar[1]}}, {BPC{bar[0]}}} : pixel_in;
`else
  assign pix = pixel_in;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rgb_out <= '0;
      blank <= 1'b1;
      h_sync <= ~SYNC_POL;
      v_sync <= ~SYNC_POL;
    end else begin
      rgb_out <= act_d ? pix : '0;
      blank <= ~act_d;
      h_sync <= hs_d ? SYNC_POL : ~SYNC_POL;
      v_sync <= vs_d ? SYNC_POL : ~SYNC_POL;
    end
endmodule

// File: tb/tb_emern_video_out.sv
// tb_emern_video_out: randomized stimulus against an index-arithmetic raster model on a small timing.
module tb_emern_video_out;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int P = 2, BPC = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CWH = $clog2(HT), CWV = $clog2(VT);
`ifdef EMERN_COLOR_BAR_EN
  localparam bit BAR = 1'b1;
`else
  localparam bit BAR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3*BPC-1:0] pixel_in = '0;
  logic test_en = 1'b0;
  logic [CWV-1:0] row;
  logic [CWH-1:0] col;
  logic frame_start, h_sync, v_sync, cmd_en, blank;
  logic [3*BPC-1:0] rgb_out;
  int checks = 0, errors = 0, k = 0, pmode = 0, tmode = 0;
  logic [3*BPC-1:0] pix[0:4095];
  bit ten[0:4095];

  always #5 clk = ~clk;

  emern_video_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0), .BPC(BPC), .PIPE_DEPTH(P)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef EMERN_COLOR_BAR_EN
    .test_en(test_en),
`endif
    .pixel_in(pixel_in),
    .row(row),
    .col(col),
    .frame_start(frame_start),
    .h_sync(h_sync),
    .v_sync(v_sync),
    .rgb_out(rgb_out),
    .cmd_en(cmd_en),
    .blank(blank)
  );

  function automatic int colm(int n); return n % HT; endfunction
  function automatic int rowm(int n); return (n / HT) % VT; endfunction
  function automatic bit actm(int n); return colm(n) < HA && rowm(n) < VA; endfunction
  function automatic bit hsm(int n); return colm(n) >= HA + HF && colm(n) < HA + HF + HS; endfunction
  function automatic bit vsm(int n); return rowm(n) >= VA + VF && rowm(n) < VA + VF + VS; endfunction
  function automatic logic [5:0] barm(int c);
    int b;
    b = c * 8 / HA;
    return 6'(((b >> 2) & 1) * 48 + ((b >> 1) & 1) * 12 + (b & 1) * 3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", nm, got, exp, k, $time);
    end
  endtask

  // one clock of stimulus; k counts edges since the last reset release
  task automatic cyc(input bit r);
    @(posedge clk);
    if (!rst) k++;
    #1;
    rst = r;
    if (r) k = 0;
    pixel_in = pmode == 1 ? 6'h3F : 6'($urandom);
    test_en = BAR && (tmode == 2 || (tmode == 1 && $urandom_range(0, 1) == 1));
    pix[k] = pixel_in;
    ten[k] = test_en;
  endtask

  initial begin
    int i, hl, vl, fs_k, hf_k;
    logic hp, vp, a, h, v;
    logic [5:0] e;
    hl = 0; vl = 0; fs_k = -1; hf_k = -1; hp = 1'b1; vp = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_col", 32'(col), 0);
        chk("rst_row", 32'(row), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_cmd", 32'(cmd_en), 0);
        chk("rst_rgb", 32'(rgb_out), 0);
        chk("rst_blank", 32'(blank), 1);
        chk("rst_hsync", 32'(h_sync), 1);
        chk("rst_vsync", 32'(v_sync), 1);
        hl = 0; vl = 0; fs_k = -1; hf_k = -1; hp = 1'b1; vp = 1'b1;
      end else begin
        i = k - P - 1;
        chk("col", 32'(col), 32'(colm(k)));
        chk("row", 32'(row), 32'(rowm(k)));
        chk("frame_start", 32'(frame_start), 32'(k > 0 && colm(k) == 0 && rowm(k) == 0));
        chk("cmd_en", 32'(cmd_en), 32'(k > 0 && rowm(k - 1) >= VA));
        a = i >= 0 && actm(i);
        h = i >= 0 && hsm(i);
        v = i >= 0 && vsm(i);
        e = a ? (ten[i] ? barm(colm(i)) : pix[k - 1]) : 6'h00;
        chk("rgb_out", 32'(rgb_out), 32'(e));
        chk("blank", 32'(blank), 32'(!a));
        chk("h_sync", 32'(h_sync), 32'(!h));
        chk("v_sync", 32'(v_sync), 32'(!v));
        if (frame_start) begin
          if (fs_k >= 0) chk("frame_period", 32'(k - fs_k), 240);
          fs_k = k;
        end
        if (!h_sync && hp) begin
          if (hf_k >= 0) chk("hs_period", 32'(k - hf_k), 24);
          hf_k = k;
        end
        if (h_sync && !hp) begin
          chk("hs_low_len", 32'(hl), 3);
          hl = 0;
        end
        if (v_sync && !vp) begin
          chk("vs_low_len", 32'(vl), 48);
          vl = 0;
        end
        if (!h_sync) hl++;
        if (!v_sync) vl++;
        hp = h_sync;
        vp = v_sync;
      end
    end
  end

  initial begin
    int n;
    repeat (3) cyc(1'b1);
    cyc(1'b0);
    cyc(1'b0);
    chk("first_col_after_rst", 32'(col), 1);
    pmode = 0;
    repeat (2 * 240) cyc(1'b0);
    pmode = 1;
    n = 0;
    while (!(rowm(k) == 3 && colm(k) == 7) && n < 300) begin
      cyc(1'b0);
      n++;
    end
    #2;
    rst = 1'b1;
    k = 0;
    #1;
    chk("async_col", 32'(col), 0);
    chk("async_row", 32'(row), 0);
    chk("async_rgb", 32'(rgb_out), 0);
    chk("async_blank", 32'(blank), 1);
    chk("async_hsync", 32'(h_sync), 1);
    cyc(1'b1);
    cyc(1'b0);
    repeat (240) cyc(1'b0);
    pmode = 0;
    tmode = 1;
    repeat (480) cyc(1'b0);
    tmode = 2;
    repeat (240) cyc(1'b0);
    tmode = 1;
    repeat (2) begin
      repeat ($urandom_range(1, 3)) cyc(1'b1);
      repeat (200 + $urandom_range(0, 99)) cyc(1'b0);
    end
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
